fir_tap_sequencer: RTL

FIR_TAP_SEQUENCER -- requirements
Module: fir_tap_sequencer

---
 rtl/fir_tap_sequencer.sv | 118 +++++++++++
 1 files changed

// File: rtl/fir_tap_sequencer.sv
// Control sequencer for a symmetric odd-length FIR filter. It keeps the
// sample delay line and drives an external time-multiplexed MAC, one tap pair per cycle.
module fir_tap_sequencer #(
  parameter int DATA_WIDTH = 3,
  parameter int OUT_WIDTH  = 23,
  parameter int NUM_TAP    = 33
) (
  input  logic                         iClk12M,
  input  logic                         iRst,
  input  logic                         iEnSample,
  input  logic signed [DATA_WIDTH-1:0] iSample,
  input  logic signed [OUT_WIDTH-1:0]  iMac,
  output logic signed [DATA_WIDTH-1:0] oDelayHead,
  output logic signed [DATA_WIDTH-1:0] oDelayTail,
  output logic [4:0]                   oCoeffAddr,
  output logic                         oEnAdd,
  output logic                         oEnAcc,
  output logic                         oEnMul,
  output logic                         oIsCenter,
  output logic signed [OUT_WIDTH-1:0]  oFirOut,
  output logic                         oValid,
  output logic                         oBusy,
  output logic                         oOverrun
);

  localparam int NUM_PAIR = (NUM_TAP - 1) / 2;
  localparam int CENTER   = NUM_PAIR;
  localparam int IDX_W    = $clog2(NUM_TAP);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t                        rState;
  state_t                        wNext;
  logic [4:0]                    rK;
  logic signed [DATA_WIDTH-1:0]  rDelay [NUM_TAP];
  logic signed [OUT_WIDTH-1:0]   rFirOut;
  logic                          rOverrun;
  logic                          wAccept;
  logic [IDX_W-1:0]              wHeadIdx;
  logic [IDX_W-1:0]              wTailIdx;

  assign wAccept  = iEnSample && (rState == ST_IDLE);
  assign wHeadIdx = IDX_W'(rK);
  assign wTailIdx = IDX_W'(NUM_TAP - 1) - IDX_W'(rK);

  // NOTE: the delay line is ordinary flops, not a RAM, so it is cleared on
  // reset; every sequential block uses <= so all registers see pre-edge values.
  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      for (int i = 0; i < NUM_TAP; i++) rDelay[i] <= '0;
    end else if (wAccept) begin
      rDelay[0] <= iSample;
      for (int i = 1; i < NUM_TAP; i++) rDelay[i] <= rDelay[i-1];
    end
  end

  always_ff @(posedge iClk12M) begin
    if (iRst) begin
      rState   <= ST_IDLE;
      rK       <= '0;
      rFirOut  <= '0;
      rOverrun <= 1'b0;
    end else begin
      rState   <= wNext;
      rOverrun <= iEnSample && (rState != ST_IDLE);
      if (wAccept) begin
        rK <= '0;
      end else if (rState == ST_MAC) begin
        rK <= (rK == 5'(CENTER)) ? 5'd0 : rK + 5'd1;
      end
      // The downstream accumulator is registered, so its final sum appears one cycle after the last tap.
      if (rState == ST_WAIT) rFirOut <= iMac;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    wNext      = rState;
    oDelayHead = '0;
    oDelayTail = '0;
    oCoeffAddr = '0;
    oEnAdd     = 1'b0;
    oEnAcc     = 1'b0;
    oEnMul     = 1'b0;
    oIsCenter  = 1'b0;
    unique case (rState)
      ST_IDLE: if (iEnSample) wNext = ST_MAC;
      ST_MAC: begin
        oCoeffAddr = rK;
        oEnMul     = 1'b1;
        oEnAdd     = (rK == 5'd0);
        oEnAcc     = (rK != 5'd0);
        oDelayHead = rDelay[wHeadIdx];
        if (rK == 5'(CENTER)) begin
          oIsCenter = 1'b1;
          wNext     = ST_WAIT;
        end else begin
          oDelayTail = rDelay[wTailIdx];
        end
      end
      ST_WAIT: wNext = ST_DONE;
      ST_DONE: wNext = ST_IDLE;
      default: wNext = ST_IDLE;
    endcase
  end

  assign oFirOut  = rFirOut;
  assign oValid   = (rState == ST_DONE);
  assign oBusy    = (rState != ST_IDLE);
  assign oOverrun = rOverrun;

endmodule
